// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC register, credit-limited imem requests, tagged instruction FIFO, redirect/flush.
// Optional misaligned-redirect trap under `IFU_ALIGN_CHECK_EN; response-to-decode latency is one cycle (registered FIFO).

module ifu_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [W-1:0]             dat_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dat_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;

  // Callers guarantee no push when full and no pop when empty.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= dat_i;
  end

  assign dat_o   = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
`ifdef IFU_ALIGN_CHECK_EN
  output logic        misalign_err,
`endif
  output logic [31:0] PC_out
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int UW = CW + 1;
  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] inst_cnt, tag_cnt, outstanding;
  logic [UW-1:0] used;
  logic [63:0]   fifo_dat;
  logic [31:0]   tag_dat, redir_tgt;
  logic          resp_ok, pop, push, req_ok, accept, block;

`ifdef IFU_ALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (reset)                                           err_q <= 1'b0;
    else if (redirect_valid && redirect_pc[1:0] != 2'b00) err_q <= 1'b1;
  end
  assign block        = err_q;
  assign misalign_err = err_q;
  assign redir_tgt    = redirect_pc;
`else
  assign block     = 1'b0;
  assign redir_tgt = redirect_pc & ~32'h3;
`endif

  // In FETCH every in-flight response owns a tag; in FLUSH only the drop count remains.
  assign outstanding = (state_q == ST_FLUSH) ? drop_q : tag_cnt;
  assign resp_ok     = imem_resp_valid && (outstanding != '0);
  assign inst_valid  = !reset && (inst_cnt != '0);
  assign pop         = inst_valid && inst_ready && !redirect_valid;
  assign push        = resp_ok && (state_q == ST_FETCH) && !redirect_valid;
  assign used        = UW'(outstanding) + UW'(inst_cnt) - UW'(pop);
  assign req_ok      = !reset && !redirect_valid && !block && (state_q == ST_FETCH) && (used < UW'(DEPTH));
  assign accept      = req_ok && imem_req_ready;

  assign imem_req_valid = req_ok;
  assign imem_addr      = pc_q;
  assign PC_out         = pc_q;
  assign inst_pc        = fifo_dat[63:32];
  assign inst_data      = fifo_dat[31:0];

  ifu_fifo #(.W(32), .DEPTH(DEPTH)) u_tag_fifo (
    .clk(clk), .reset(reset), .clear_i(redirect_valid),
    .push_i(accept), .dat_i(pc_q), .pop_i(push),
    .dat_o(tag_dat), .count_o(tag_cnt)
  );

  ifu_fifo #(.W(64), .DEPTH(DEPTH)) u_inst_fifo (
    .clk(clk), .reset(reset), .clear_i(redirect_valid),
    .push_i(push), .dat_i({tag_dat, imem_resp_data}), .pop_i(pop),
    .dat_o(fifo_dat), .count_o(inst_cnt)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    if (redirect_valid) begin
      pc_d    = redir_tgt;
      drop_d  = outstanding - CW'(resp_ok);
      state_d = (drop_d != '0) ? ST_FLUSH : ST_FETCH;
    end else if (state_q == ST_FLUSH) begin
      if (resp_ok) drop_d = drop_q - CW'(1);
      if (drop_d == '0) state_d = ST_FETCH;
    end else if (accept) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, corner sequences, and random traffic against a queue-based model.
module tb_instr_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic        N = 1'b0;
  localparam logic        Y = 1'b1;

  logic        clk = 1'b0;
  logic        reset, redirect_valid, imem_req_valid, imem_req_ready;
  logic        imem_resp_valid, inst_valid, inst_ready;
  logic [31:0] redirect_pc, imem_addr, imem_resp_data, inst_data, inst_pc, PC_out;
`ifdef IFU_ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
`ifdef IFU_ALIGN_CHECK_EN
    .misalign_err(misalign_err),
`endif
    .PC_out(PC_out)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [31:0] dfun(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Reference model: queues of in-flight PCs and buffered {pc,data}, plus a stale-response count.
  logic [31:0] m_pc;
  logic [31:0] m_infl[$];
  logic [63:0] m_fifo[$];
  int          m_drop;
  logic        m_err;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t memq[$];
  int    cyc, last_due, lat_lo, lat_hi;

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0; inst_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_pc_out", PC_out, RESET_PC);
    chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
`ifdef IFU_ALIGN_CHECK_EN
    chk("rst_misalign", {31'h0, misalign_err}, 32'h0);
`endif
    reset = 1'b0;
    m_pc = RESET_PC; m_infl.delete(); m_fifo.delete(); m_drop = 0; m_err = 1'b0;
    memq.delete(); cyc = 0; last_due = -1;
  endtask

  task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy, input logic ird);
    logic        rv, e_iv, e_pop, e_req, resp;
    logic [31:0] rdat, tag;
    logic [63:0] head;
    int          used, outst, due;
    rv   = (memq.size() > 0) && (memq[0].due <= cyc);
    rdat = rv ? dfun(memq[0].addr) : $urandom;
    redirect_valid = rd; redirect_pc = rpc; imem_req_ready = rdy; inst_ready = ird;
    imem_resp_valid = rv; imem_resp_data = rdat;
    e_iv  = m_fifo.size() > 0;
    e_pop = e_iv && ird && !rd;
    used  = m_infl.size() + m_fifo.size() - (e_pop ? 1 : 0);
    e_req = !rd && m_drop == 0 && !m_err && used < DEPTH;
    #2;
    chk("req_valid", {31'h0, imem_req_valid}, {31'h0, e_req});
    chk("imem_addr", imem_addr, m_pc);
    chk("pc_out", PC_out, m_pc);
    chk("inst_valid", {31'h0, inst_valid}, {31'h0, e_iv});
    if (e_iv) begin
      head = m_fifo[0];
      chk("inst_pc", inst_pc, head[63:32]);
      chk("inst_data", inst_data, head[31:0]);
    end
`ifdef IFU_ALIGN_CHECK_EN
    chk("misalign_err", {31'h0, misalign_err}, {31'h0, m_err});
`endif
    @(posedge clk);
    outst = m_infl.size() + m_drop;
    resp  = rv && outst > 0;
    if (rv) void'(memq.pop_front());
    if (e_req && rdy) begin
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{addr: m_pc, due: due});
    end
    if (rd) begin
      m_drop = outst - (resp ? 1 : 0);
      m_infl.delete(); m_fifo.delete();
`ifdef IFU_ALIGN_CHECK_EN
      m_pc = rpc;
      if (rpc[1:0] != 2'b00) m_err = 1'b1;
`else
      m_pc = rpc & 32'hFFFF_FFFC;
`endif
    end else begin
      if (e_pop) void'(m_fifo.pop_front());
      if (resp) begin
        if (m_drop > 0) m_drop--;
        else begin
          tag = m_infl.pop_front();
          m_fifo.push_back({tag, rdat});
        end
      end
      if (e_req && rdy) begin
        m_infl.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic wait_iv(input int maxc, input logic [31:0] exp_pc, input string nm);
    for (int i = 0; i < maxc && !inst_valid; i++) step(N, 32'h0, Y, N);
    chk({nm, "_valid"}, {31'h0, inst_valid}, 32'h1);
    chk({nm, "_pc"}, inst_pc, exp_pc);
  endtask

  typedef struct {
    logic rd; logic [31:0] rpc; logic rdy; logic rv; logic [31:0] raddr; logic ird;
    logic e_req; logic [31:0] e_addr; logic e_iv; logic [31:0] e_ipc;
  } vec_t;
  vec_t tbl[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{N, 32'h0,   Y, N, 32'h0,         Y, Y, 32'h0,   N, 32'h0};
    tbl[1]  = '{N, 32'h0,   Y, Y, 32'h0,         Y, Y, 32'h4,   N, 32'h0};
    tbl[2]  = '{N, 32'h0,   Y, Y, 32'h4,         Y, Y, 32'h8,   Y, 32'h0};
    tbl[3]  = '{N, 32'h0,   Y, Y, 32'h8,         Y, Y, 32'hC,   Y, 32'h4};
    tbl[4]  = '{Y, 32'h100, Y, Y, 32'hC,         Y, N, 32'h10,  Y, 32'h8};
    tbl[5]  = '{N, 32'h0,   Y, N, 32'h0,         Y, Y, 32'h100, N, 32'h0};
    tbl[6]  = '{N, 32'h0,   Y, Y, 32'h100,       Y, Y, 32'h104, N, 32'h0};
    tbl[7]  = '{N, 32'h0,   Y, Y, 32'h104,       N, Y, 32'h108, Y, 32'h100};
    tbl[8]  = '{N, 32'h0,   N, Y, 32'h108,       N, Y, 32'h10C, Y, 32'h100};
    tbl[9]  = '{N, 32'h0,   Y, N, 32'h0,         N, Y, 32'h10C, Y, 32'h100};
    tbl[10] = '{N, 32'h0,   Y, Y, 32'h10C,       N, N, 32'h110, Y, 32'h100};
    tbl[11] = '{N, 32'h0,   Y, Y, 32'h0BAD_0000, N, N, 32'h110, Y, 32'h100};
    tbl[12] = '{N, 32'h0,   Y, N, 32'h0,         Y, Y, 32'h110, Y, 32'h100};
    tbl[13] = '{N, 32'h0,   N, Y, 32'h110,       Y, Y, 32'h114, Y, 32'h104};
    tbl[14] = '{N, 32'h0,   Y, N, 32'h0,         Y, Y, 32'h114, Y, 32'h108};
    tbl[15] = '{N, 32'h0,   Y, Y, 32'h114,       Y, Y, 32'h118, Y, 32'h10C};

    // Directed table: streaming, redirect with same-cycle response, backpressure, stray response.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      redirect_valid  = tbl[i].rd;  redirect_pc    = tbl[i].rpc;
      imem_req_ready  = tbl[i].rdy; imem_resp_valid = tbl[i].rv;
      imem_resp_data  = dfun(tbl[i].raddr); inst_ready = tbl[i].ird;
      #2;
      chk($sformatf("tbl%0d_req", i), {31'h0, imem_req_valid}, {31'h0, tbl[i].e_req});
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_iv", i), {31'h0, inst_valid}, {31'h0, tbl[i].e_iv});
      if (tbl[i].e_iv) begin
        chk($sformatf("tbl%0d_ipc", i), inst_pc, tbl[i].e_ipc);
        chk($sformatf("tbl%0d_idata", i), inst_data, dfun(tbl[i].e_ipc));
      end
      @(posedge clk); #1;
    end

    // Latency 3, two in flight, redirect: both stale responses dropped.
    do_reset(); lat_lo = 3; lat_hi = 3;
    step(N, 32'h0, Y, N);
    step(N, 32'h0, Y, N);
    step(Y, 32'h100, Y, N);
    wait_iv(20, 32'h100, "flush_first");

    // Redirect coinciding with a response and a pop.
    do_reset(); lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 4; i++) step(N, 32'h0, Y, Y);
    step(Y, 32'h200, Y, Y);
    chk("redir_fifo_empty", {31'h0, inst_valid}, 32'h0);
    wait_iv(10, 32'h200, "redir_first");

    // Fetch PC wrap at the top of the address space.
    step(Y, 32'hFFFF_FFF8, Y, Y);
    step(N, 32'h0, Y, Y);
    step(N, 32'h0, Y, Y);
    chk("wrap_pc", PC_out, 32'h0);
    for (int i = 0; i < 6; i++) step(N, 32'h0, Y, Y);

    // Misaligned redirect.
    step(Y, 32'h102, Y, Y);
`ifdef IFU_ALIGN_CHECK_EN
    for (int i = 0; i < 6; i++) step(N, 32'h0, Y, Y);
    chk("misalign_set", {31'h0, misalign_err}, 32'h1);
    chk("misalign_block", {31'h0, imem_req_valid}, 32'h0);
    do_reset();
    chk("misalign_clr", {31'h0, misalign_err}, 32'h0);
`else
    chk("align_force", imem_addr, 32'h100);
    for (int i = 0; i < 6; i++) step(N, 32'h0, Y, Y);
`endif

    // Random traffic against the model.
    do_reset(); lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 800; i++) begin
      logic        rd, rdy, ird;
      logic [31:0] rpc;
      rd  = ($urandom_range(99, 0) < 4);
`ifdef IFU_ALIGN_CHECK_EN
      rpc = $urandom & 32'hFFFF_FFFC;
`else
      rpc = $urandom;
`endif
      rdy = ($urandom_range(3, 0) != 0);
      ird = ($urandom_range(9, 0) < 7);
      step(rd, rpc, rdy, ird);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
